// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS generator/checker family.
//   - prbs_state_e  : checker state machine encoding (SEED, VERIFY, LOCKED)
//   - PRBS_DEF_*    : default parameter values for prbs_checker
//   - prbs_feedback : feedback bit for polynomial x^N + x^(N-1) + 1, computed
//                     from the bits at tap positions N and N-1 (shared with lfsr)
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS_SEED   = 2'd0,
    PRBS_VERIFY = 2'd1,
    PRBS_LOCKED = 2'd2
  } prbs_state_e;

  localparam int PRBS_DEF_N           = 64;
  localparam int PRBS_DEF_LOCK_COUNT  = 64;
  localparam int PRBS_DEF_WINDOW_LEN  = 1024;
  localparam int PRBS_DEF_LOSS_THRESH = 16;
  localparam int PRBS_DEF_ERR_W       = 32;

  function automatic logic prbs_feedback(input logic tap_n, input logic tap_nm1);
    return tap_n ^ tap_nm1;
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (count -> 0)
//   clear   : synchronous clear, takes priority over inc
//   inc     : increment request for this cycle
//   count   : registered count value
module prbs_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS checker for polynomial x^N + x^(N-1) + 1.
// Self-seeds from the received stream, verifies it, declares lock, counts bit
// errors while locked and drops lock when too many errors land in one window.
//   clk       : clock, rising edge
//   reset_n   : asynchronous active-low reset
//   in_valid  : in_bit is valid this cycle; all state holds otherwise
//   in_bit    : received serial bit
//   clear     : synchronous clear of err_count and bit_count
//   locked    : checker is synchronised
//   err_pulse : one-cycle strobe per counted error
//   err_count : saturating count of errors seen while locked
//   bit_count : saturating count of valid bits checked while locked
// Build option: define PRBS_CHK_BITCNT_EN to build the bit_count counter;
// otherwise bit_count is tied to 0.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int N           = PRBS_DEF_N,
  parameter int LOCK_COUNT  = PRBS_DEF_LOCK_COUNT,
  parameter int WINDOW_LEN  = PRBS_DEF_WINDOW_LEN,
  parameter int LOSS_THRESH = PRBS_DEF_LOSS_THRESH,
  parameter int ERR_W       = PRBS_DEF_ERR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] bit_count
);

  localparam int FILL_W = $clog2(N);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int WBIT_W = $clog2(WINDOW_LEN + 1);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  // Bit 0 of s holds position 1 (newest bit), bit N-1 holds position N.
  prbs_state_e       state_q, state_d;
  logic [N-1:0]      s_q, s_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [WBIT_W-1:0] wbit_q, wbit_d;
  logic [WERR_W-1:0] werr_q, werr_d;
  logic              locked_q, locked_d;
  logic              err_pulse_q, err_pulse_d;
  logic              exp_bit, mismatch, err_inc;

  always_comb begin
    exp_bit     = prbs_feedback(s_q[N-1], s_q[N-2]);
    mismatch    = in_bit ^ exp_bit;
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    good_d      = good_q;
    wbit_d      = wbit_q;
    werr_d      = werr_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    if (in_valid) begin
      case (state_q)
        PRBS_SEED: begin
          s_d = {s_q[N-2:0], in_bit};
          if (fill_q == FILL_W'(N - 1)) begin
            fill_d = '0;
            // An all-zero seed would lock onto the degenerate all-zero sequence.
            if (s_d != '0) state_d = PRBS_VERIFY;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        PRBS_VERIFY: begin
          // Still self-synchronising: the received bit keeps reseeding S.
          s_d = {s_q[N-2:0], in_bit};
          if (mismatch) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_COUNT - 1)) begin
            good_d  = '0;
            wbit_d  = '0;
            werr_d  = '0;
            state_d = PRBS_LOCKED;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end
        PRBS_LOCKED: begin
          // Free-running on the prediction so a flipped bit cannot poison S.
          s_d         = {s_q[N-2:0], exp_bit};
          err_inc     = mismatch;
          err_pulse_d = mismatch;
          if (mismatch && (werr_q == WERR_W'(LOSS_THRESH - 1))) begin
            state_d = PRBS_SEED;
            fill_d  = '0;
            good_d  = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else if (wbit_q == WBIT_W'(WINDOW_LEN - 1)) begin
            wbit_d = '0;
            werr_d = '0;
          end else begin
            wbit_d = wbit_q + WBIT_W'(1);
            werr_d = werr_q + WERR_W'(mismatch);
          end
        end
        default: state_d = PRBS_SEED;
      endcase
    end
    locked_d = (state_d == PRBS_LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PRBS_SEED;
      s_q         <= '0;
      fill_q      <= '0;
      good_q      <= '0;
      wbit_q      <= '0;
      werr_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      good_q      <= good_d;
      wbit_q      <= wbit_d;
      werr_q      <= werr_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

  prbs_sat_counter #(.WIDTH(ERR_W)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (err_inc),
    .count   (err_count)
  );

`ifdef PRBS_CHK_BITCNT_EN
  logic bit_inc;
  assign bit_inc = in_valid && (state_q == PRBS_LOCKED);

  prbs_sat_counter #(.WIDTH(ERR_W)) u_bit_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (bit_inc),
    .count   (bit_count)
  );
`else
  assign bit_count = '0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed bench for prbs_checker with N=7, LOCK_COUNT=16,
// WINDOW_LEN=64, LOSS_THRESH=4. Stimulus comes from a PRBS7 generator seeded
// with 7'h01. Two checker instances share the stimulus: ERR_W=32 and ERR_W=3.
module tb_prbs_checker;

  localparam int N           = 7;
  localparam int LOCK_COUNT  = 16;
  localparam int WINDOW_LEN  = 64;
  localparam int LOSS_THRESH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse;
  logic [31:0] err_count, bit_count;
  logic        locked3, err_pulse3;
  logic [2:0]  err_count3, bit_count3;

  always #5 clk = ~clk;

  prbs_checker #(.N(N), .LOCK_COUNT(LOCK_COUNT), .WINDOW_LEN(WINDOW_LEN),
                 .LOSS_THRESH(LOSS_THRESH), .ERR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  prbs_checker #(.N(N), .LOCK_COUNT(LOCK_COUNT), .WINDOW_LEN(WINDOW_LEN),
                 .LOSS_THRESH(LOSS_THRESH), .ERR_W(3)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear(clear), .locked(locked3), .err_pulse(err_pulse3),
    .err_count(err_count3), .bit_count(bit_count3)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;

  // Generator state (PRBS7, taps 7 and 6).
  logic [6:0] gen;

  // Behavioural model of the checker, driven straight from the rules.
  int          m_mode;        // 0 = seeding, 1 = verifying, 2 = locked
  bit          m_hist[$];     // received/predicted history, newest first
  int          m_fill, m_good, m_winb, m_wine;
  int unsigned m_err, m_bitc, m_err3, m_bitc3;
  bit          m_pulse, m_locked;

  function automatic void m_reset();
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_good = 0; m_winb = 0; m_wine = 0;
    m_err = 0; m_bitc = 0; m_err3 = 0; m_bitc3 = 0;
    m_pulse = 0; m_locked = 0;
  endfunction

  function automatic void m_push(input bit b);
    m_hist.push_front(b);
    void'(m_hist.pop_back());
  endfunction

  function automatic void m_step(input bit v, input bit b, input bit c);
    bit e, mm, any_one, inc_err, inc_bit;
    inc_err = 0;
    inc_bit = 0;
    m_pulse = 0;
    if (v) begin
      e  = m_hist[N-1] ^ m_hist[N-2];
      mm = (b != e);
      case (m_mode)
        0: begin
          m_push(b);
          m_fill++;
          if (m_fill == N) begin
            m_fill = 0;
            any_one = 0;
            foreach (m_hist[i]) if (m_hist[i]) any_one = 1;
            if (any_one) begin m_mode = 1; m_good = 0; end
          end
        end
        1: begin
          m_push(b);
          if (mm) m_good = 0;
          else begin
            m_good++;
            if (m_good == LOCK_COUNT) begin
              m_mode = 2; m_good = 0; m_winb = 0; m_wine = 0;
            end
          end
        end
        default: begin
          m_push(e);
          inc_bit = 1;
          m_winb++;
          if (mm) begin m_pulse = 1; inc_err = 1; m_wine++; end
          if (m_wine == LOSS_THRESH) begin
            m_mode = 0; m_fill = 0; m_good = 0; m_winb = 0; m_wine = 0;
          end else if (m_winb == WINDOW_LEN) begin
            m_winb = 0; m_wine = 0;
          end
        end
      endcase
    end
    m_locked = (m_mode == 2);
    if (c) begin
      m_err = 0; m_bitc = 0; m_err3 = 0; m_bitc3 = 0;
    end else begin
      if (inc_err && m_err != 32'hFFFF_FFFF) m_err++;
      if (inc_bit && m_bitc != 32'hFFFF_FFFF) m_bitc++;
      if (inc_err && m_err3 < 7) m_err3++;
      if (inc_bit && m_bitc3 < 7) m_bitc3++;
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic compare_model();
    int unsigned eb, eb3;
`ifdef PRBS_CHK_BITCNT_EN
    eb = m_bitc; eb3 = m_bitc3;
`else
    eb = 0; eb3 = 0;
`endif
    vectors++;
    if (locked !== m_locked || err_pulse !== m_pulse || err_count !== m_err ||
        bit_count !== eb || locked3 !== m_locked || err_pulse3 !== m_pulse ||
        err_count3 !== 3'(m_err3) || bit_count3 !== 3'(eb3)) begin
      miscompares++;
      $display("FAIL cycle t=%0t got lk=%0b pl=%0b ec=%0d bc=%0d lk3=%0b pl3=%0b ec3=%0d bc3=%0d exp lk=%0b pl=%0b ec=%0d bc=%0d ec3=%0d bc3=%0d",
               $time, locked, err_pulse, err_count, bit_count, locked3, err_pulse3,
               err_count3, bit_count3, m_locked, m_pulse, m_err, eb, m_err3, eb3);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v; in_bit = b; clear = c;
    @(posedge clk);
    m_step(v, b, c);
    @(negedge clk);
    if (err_pulse) pulses++;
    compare_model();
  endtask

  task automatic gen_next(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  task automatic clean(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen_next(b);
      step(1'b1, b, 1'b0);
    end
  endtask

  task automatic flip(input logic c);
    logic b;
    gen_next(b);
    step(1'b1, ~b, c);
  endtask

  task automatic acquire(output int nbits);
    logic b;
    nbits = 0;
    while (!locked && nbits < 200) begin
      gen_next(b);
      step(1'b1, b, 1'b0);
      nbits++;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0;
    m_reset();
    gen = 7'h01;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {locked, err_pulse, err_count, bit_count,
                          locked3, err_pulse3, err_count3, bit_count3}, 0);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, cyc, vb;
    logic b;
    logic [6:0] first7;

    // Generator reference: seed 0000001 gives 0,0,0,0,0,1,1 as first outputs.
    gen = 7'h01;
    first7 = '0;
    for (int i = 0; i < 7; i++) begin
      gen_next(b);
      first7 = {first7[5:0], b};
    end
    chk("gen_first7", first7, 7'b0000011);

    // Clean acquisition.
    do_reset();
    acquire(n);
    chk("lock_bits", n, 23);
    chk("lock_err_count", err_count, 0);
    clean(10);
`ifdef PRBS_CHK_BITCNT_EN
    chk("bit_count_10", bit_count, 10);
`else
    chk("bit_count_off", bit_count, 0);
`endif

    // Single-bit errors spaced 100 bits apart.
    pulses = 0;
    flip(1'b0);
    for (int i = 0; i < 3; i++) begin
      clean(99);
      flip(1'b0);
    end
    clean(5);
    chk("single_pulses", pulses, 4);
    chk("single_err_count", err_count, 4);
    chk("single_locked", locked, 1);

    // Loss of sync: four errors within one window.
    do_reset();
    acquire(n);
    clean(5);
    flip(1'b0); clean(1);
    flip(1'b0); clean(1);
    flip(1'b0); clean(1);
    flip(1'b0);
    chk("loss_locked", locked, 0);
    chk("loss_err_count", err_count, 4);
    acquire(n);
    chk("relock_bits", n, 23);

    // Gapped valid.
    do_reset();
    cyc = 0; vb = 0;
    while (!locked && cyc < 400) begin
      step(1'b0, 1'($urandom), 1'b0);
      cyc++;
      gen_next(b);
      step(1'b1, b, 1'b0);
      cyc++; vb++;
    end
    chk("gap_valid_bits", vb, 23);
    chk("gap_cycles", cyc, 46);

    // All-zero stream never leaves seeding.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b0, 1'b0);
    chk("zero_locked", locked, 0);

    // Clear vs. same-cycle error, then saturation of the 3-bit counter.
    do_reset();
    acquire(n);
    clean(3);
    flip(1'b1);
    chk("clear_err_count", err_count, 0);
    chk("clear_err_count3", err_count3, 0);
    for (int i = 0; i < 9; i++) begin
      clean(30);
      flip(1'b0);
    end
    chk("sat_err_count32", err_count, 9);
    chk("sat_err_count3", err_count3, 7);
    chk("sat_locked", locked, 1);

    // Asynchronous reset while locked, with a pulse in flight.
    clean(30);
    flip(1'b0);
    #2;
    reset_n = 1'b0;
    m_reset();
    #1;
    chk("async_reset", {locked, err_pulse, err_count, bit_count,
                        locked3, err_pulse3, err_count3, bit_count3}, 0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
